// File: rtl/pad_cfg_pkg.sv
// Shared definitions for the APB pad configuration controller.
// - Register byte offsets (CFG_BASE, COMMIT_OFS, STATUS_OFS, LOCK_OFS)
// - Default geometry (N_PADS, CFG_W) and the per-pad config type
package pad_cfg_pkg;
  localparam int N_PADS = 48;
  localparam int CFG_W  = 6;

  localparam logic [11:0] CFG_BASE   = 12'h000;
  localparam logic [11:0] COMMIT_OFS = 12'h100;
  localparam logic [11:0] STATUS_OFS = 12'h104;
  localparam logic [11:0] LOCK_OFS   = 12'h108;

  typedef logic [CFG_W-1:0] pad_cfg_t;
endpackage

// File: rtl/pad_cfg_bank.sv
// Shadow + active pad configuration register pair.
// - clk_i, rst_i : clock, synchronous active-high reset
// - wr_en_i      : per-pad shadow write enable
// - wdata_i      : per-pad shadow write data
// - commit_i     : copy the whole shadow bank into the active bank
// - shadow_o     : shadow bank (software view)
// - active_o     : active bank (drives the pad frame)
module pad_cfg_bank
  import pad_cfg_pkg::*;
#(
  parameter int N_PADS = 48,
  parameter int CFG_W  = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_PADS-1:0]              wr_en_i,
  input  logic [N_PADS-1:0][CFG_W-1:0]   wdata_i,
  input  logic                           commit_i,
  output logic [N_PADS-1:0][CFG_W-1:0]   shadow_o,
  output logic [N_PADS-1:0][CFG_W-1:0]   active_o
);
  logic [N_PADS-1:0][CFG_W-1:0] shadow_d, shadow_q;
  logic [N_PADS-1:0][CFG_W-1:0] active_d, active_q;

  always_comb begin
    shadow_d = shadow_q;
    for (int p = 0; p < N_PADS; p++) begin
      if (wr_en_i[p]) shadow_d[p] = wdata_i[p];
    end
    // Commit and shadow write never coincide (one APB transfer per cycle),
    // so copying the pre-edge shadow is exact.
    active_d = commit_i ? shadow_q : active_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;
endmodule

// File: rtl/apb_pad_cfg_ctrl.sv
// APB4 slave owning the pad frame configuration (shadow/commit scheme).
// - APB: psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
//        prdata_o, pready_o (always 1), pslverr_o
// - pad_cfg_o     : active bank, registered; bit0 per pad = pull-disable
// - cfg_pending_o : shadow written since last commit
// Optional feature macro: PAD_CFG_LOCK_EN adds the sticky LOCK register at
// 0x108 and STATUS bit1; without it 0x108 is unmapped.
module apb_pad_cfg_ctrl #(
  parameter int N_PADS     = pad_cfg_pkg::N_PADS,
  parameter int CFG_W      = pad_cfg_pkg::CFG_W,
  parameter int APB_ADDR_W = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pwrite_i,
  input  logic [APB_ADDR_W-1:0]         paddr_i,
  input  logic [31:0]                   pwdata_i,
  input  logic [3:0]                    pstrb_i,
  output logic [31:0]                   prdata_o,
  output logic                          pready_o,
  output logic                          pslverr_o,
  output logic [N_PADS-1:0][CFG_W-1:0]  pad_cfg_o,
  output logic                          cfg_pending_o
);
  import pad_cfg_pkg::*;

  localparam int N_WORDS = N_PADS / 4;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  logic [APB_ADDR_W-1:0] addr_w, cfg_ofs;
  logic [IDX_W-1:0]      word_idx;
  logic access, cfg_hit, commit_hit, status_hit, lock_hit, mapped, err;
  logic wr_ok, cfg_wr, commit;
  logic locked;
  logic pending_d, pending_q;
  logic [N_PADS-1:0]             wr_en;
  logic [N_PADS-1:0][CFG_W-1:0]  wdata, shadow;

  // Reset dominates: no transfer is seen while rst_i is high.
  assign access   = psel_i & penable_i & ~rst_i;
  assign addr_w   = {paddr_i[APB_ADDR_W-1:2], 2'b00};
  // Byte offset into the CFG window equals the pad index (4 pads per word).
  assign cfg_ofs  = addr_w - APB_ADDR_W'(CFG_BASE);
  assign cfg_hit  = cfg_ofs < APB_ADDR_W'(N_PADS);
  assign word_idx = cfg_ofs[IDX_W+1:2];

  assign commit_hit = addr_w == APB_ADDR_W'(COMMIT_OFS);
  assign status_hit = addr_w == APB_ADDR_W'(STATUS_OFS);

`ifdef PAD_CFG_LOCK_EN
  logic locked_d, locked_q, lock_set;
  assign lock_hit = addr_w == APB_ADDR_W'(LOCK_OFS);
  assign lock_set = wr_ok & lock_hit & pwdata_i[0];
  assign locked_d = locked_q | lock_set;  // sticky until reset
  always_ff @(posedge clk_i) begin
    if (rst_i) locked_q <= 1'b0;
    else       locked_q <= locked_d;
  end
  assign locked = locked_q;
`else
  assign lock_hit = 1'b0;
  assign locked   = 1'b0;
`endif

  assign mapped = cfg_hit | commit_hit | status_hit | lock_hit;
  assign err    = access & (~mapped |
                  (pwrite_i & (status_hit | (locked & (cfg_hit | commit_hit | lock_hit)))));
  assign wr_ok  = access & pwrite_i & ~err;
  assign cfg_wr = wr_ok & cfg_hit;
  assign commit = wr_ok & commit_hit & pwdata_i[0];

  always_comb begin
    for (int p = 0; p < N_PADS; p++) begin
      wr_en[p] = cfg_wr & (word_idx == IDX_W'(p / 4)) & pstrb_i[p % 4];
      wdata[p] = pwdata_i[8*(p % 4) +: CFG_W];
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (cfg_wr) pending_d = 1'b1;
    if (commit) pending_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pending_q <= 1'b0;
    else       pending_q <= pending_d;
  end

  pad_cfg_bank #(.N_PADS(N_PADS), .CFG_W(CFG_W)) u_bank (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (wr_en),
    .wdata_i  (wdata),
    .commit_i (commit),
    .shadow_o (shadow),
    .active_o (pad_cfg_o)
  );

  always_comb begin
    prdata_o = '0;
    if (access & ~err) begin
      if (cfg_hit) begin
        for (int b = 0; b < 4; b++)
          prdata_o[8*b +: CFG_W] = shadow[{word_idx, 2'(b)}];
      end else if (status_hit) begin
        prdata_o[1:0] = {locked, pending_q};
      end else if (lock_hit) begin
        prdata_o[0] = locked;
      end
    end
  end

  assign pslverr_o     = err;
  assign pready_o      = 1'b1;
  assign cfg_pending_o = pending_q;

  logic unused_bits;
  assign unused_bits = ^{paddr_i[1:0], pwdata_i};
endmodule

// File: tb/tb_apb_pad_cfg_ctrl.sv
// Scoreboard bench for apb_pad_cfg_ctrl: stimulus pushes the expected APB
// response per transfer; a monitor pops and compares on every ACCESS cycle.
// Pad/pending outputs are checked directly against hand-computed constants.
module tb_apb_pad_cfg_ctrl;
  logic clk = 0, rst = 1;
  logic psel = 0, penable = 0, pwrite = 0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata;
  logic pready, pslverr, pending;
  logic [47:0][5:0] pad_cfg;

  apb_pad_cfg_ctrl dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .pad_cfg_o(pad_cfg), .cfg_pending_o(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every completed transfer pops one expectation.
  always @(negedge clk) begin
    if (psel && penable) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: got transfer at %h want none", paddr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_pready"}, {31'b0, pready}, 32'd1);
        chk({e.nm, "_pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
        if (e.chk_data) chk({e.nm, "_prdata"}, prdata, e.data);
      end
    end
  end

  task automatic apb_start(input bit wr, input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit chkd, input logic [31:0] ed,
                           input bit ee, input string nm);
    exp_t e;
    e.nm = nm; e.chk_data = chkd; e.data = ed; e.err = ee;
    sb.push_back(e);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1 penable = 1;
  endtask

  task automatic apb_end();
    @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] ed, input bit ee, input string nm);
    apb_start(0, a, 32'h0, 4'h0, 1, ed, ee, nm); apb_end();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input bit ee, input string nm);
    apb_start(1, a, d, s, 0, 32'h0, ee, nm); apb_end();
  endtask

  task automatic chk_pad(input int i, input logic [5:0] e);
    chk($sformatf("pad%0d", i), {26'b0, pad_cfg[i]}, {26'b0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_pads_zero", {31'b0, pad_cfg == '0}, 32'd1);
    chk("rst_pending", {31'b0, pending}, 32'd0);
    rd(12'h000, 32'h0, 0, "rst_cfg0");
    rd(12'h104, 32'h0, 0, "rst_status");

    // Shadow write + readback, active untouched
    wr(12'h004, 32'h3F2A153F, 4'hF, 0, "wr_cfg1");
    rd(12'h004, 32'h3F2A153F, 0, "rd_cfg1");
    for (int i = 4; i < 8; i++) chk_pad(i, 6'h00);
    chk("pending_set", {31'b0, pending}, 32'd1);
    rd(12'h104, 32'h1, 0, "status_pend");

    // Commit: active changes only after the access edge
    apb_start(1, 12'h100, 32'h1, 4'hF, 0, 32'h0, 0, "commit1");
    chk_pad(4, 6'h00);
    apb_end();
    chk_pad(4, 6'h3F); chk_pad(5, 6'h15); chk_pad(6, 6'h2A); chk_pad(7, 6'h3F);
    chk("pending_clr", {31'b0, pending}, 32'd0);

    // Commit with bit0=0 has no effect
    wr(12'h000, 32'h00000001, 4'h1, 0, "wr_cfg0");
    wr(12'h100, 32'h0, 4'hF, 0, "commit0");
    chk_pad(0, 6'h00);
    chk("pending_hold", {31'b0, pending}, 32'd1);

    // Single strobe lane, unused bits dropped
    wr(12'h008, 32'hFFFFFFFF, 4'h2, 0, "wr_strb");
    rd(12'h008, 32'h00003F00, 0, "rd_strb");

    wr(12'h100, 32'h1, 4'hF, 0, "commit2");
    chk_pad(0, 6'h01); chk_pad(9, 6'h3F); chk_pad(8, 6'h00); chk_pad(4, 6'h3F);
    chk("pending_clr2", {31'b0, pending}, 32'd0);
    wr(12'h100, 32'h1, 4'hF, 0, "commit_idle");
    chk_pad(9, 6'h3F); chk_pad(0, 6'h01);

    // Error responses, no state change
    rd(12'h0FC, 32'h0, 1, "rd_unmap");
    wr(12'h0FC, 32'hFFFFFFFF, 4'hF, 1, "wr_unmap");
    wr(12'h104, 32'hFFFFFFFF, 4'hF, 1, "wr_status");
    rd(12'h104, 32'h0, 0, "status_after_err");
    rd(12'h000, 32'h00000001, 0, "cfg0_after_err");
`ifdef PAD_CFG_LOCK_EN
    wr(12'h108, 32'h1, 4'hF, 0, "lock");
    rd(12'h104, 32'h2, 0, "status_locked");
    wr(12'h000, 32'hFFFFFFFF, 4'hF, 1, "wr_cfg_locked");
    wr(12'h100, 32'h1, 4'hF, 1, "commit_locked");
    wr(12'h108, 32'h1, 4'hF, 1, "lock_locked");
    rd(12'h000, 32'h00000001, 0, "cfg0_locked");
    chk("pending_locked", {31'b0, pending}, 32'd0);
`else
    wr(12'h108, 32'h1, 4'hF, 1, "wr_lock_unmap");
    rd(12'h108, 32'h0, 1, "rd_lock_unmap");
    rd(12'h104, 32'h0, 0, "status_nolock");
`endif

    // Reset during the ACCESS phase of a CFG write
    apb_start(1, 12'h00C, 32'h3F3F3F3F, 4'hF, 1, 32'h0, 0, "rst_mid");
    rst = 1;
    apb_end();
    rst = 0;
    chk("mid_pads_zero", {31'b0, pad_cfg == '0}, 32'd1);
    chk("mid_pending", {31'b0, pending}, 32'd0);
    rd(12'h00C, 32'h0, 0, "mid_cfg3");
    rd(12'h004, 32'h0, 0, "mid_cfg1");
    rd(12'h104, 32'h0, 0, "mid_status");

    repeat (2) @(posedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
